// File: rtl/acs_scheduler.sv
// Time-multiplexed ACS scheduler, K=3 r=1/2: 4 RUN cycles + COMMIT per symbol, survivor held in OUT until surv_ready.
// Optional ACS_SCHED_BEST_STATE_EN adds best_state (argmin of the normalized metrics, lowest index on ties).
module acs_scheduler #(
  parameter int PM_W    = 7,
  parameter int INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            sym_valid,
  input  logic [1:0]      sym_data,
  output logic            sym_ready,
  output logic            acs_en,
  output logic [1:0]      acs_state,
  output logic [1:0]      acs_data,
  output logic [PM_W-1:0] acs_pm1,
  output logic [PM_W-1:0] acs_pm2,
  input  logic [PM_W-1:0] acs_pm_out,
  input  logic            acs_dec,
  output logic            surv_valid,
  output logic [3:0]      surv_bits,
  input  logic            surv_ready
`ifdef ACS_SCHED_BEST_STATE_EN
  ,
  output logic [1:0]      best_state
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  localparam logic [PM_W-1:0] HALF   = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  logic [1:0]      state;
  logic [1:0]      idx;
  logic [1:0]      sym_q;
  logic [3:0]      surv_q;
  logic [PM_W-1:0] pm     [4];
  logic [PM_W-1:0] nxt_pm [4];
  logic [PM_W-1:0] norm_pm[4];
  logic [PM_W-1:0] min_pm;
  logic            do_norm;
  logic            run;

  assign run       = (state == RUN);
  assign sym_ready = (state == IDLE);
  assign acs_en    = run;

  // Operands are forced to zero outside RUN so idle outputs match the reset values.
  always_comb begin
    acs_state = 2'd0;
    acs_data  = 2'd0;
    acs_pm1   = '0;
    acs_pm2   = '0;
    if (run) begin
      acs_state = idx;
      acs_data  = sym_q;
      acs_pm1   = pm[{idx[0], 1'b0}];
      acs_pm2   = pm[{idx[0], 1'b1}];
    end
  end

  always_comb begin
    min_pm = nxt_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (nxt_pm[i] < min_pm) min_pm = nxt_pm[i];
    end
  end

  // Normalization only ever removes the top half, keeping all metrics in range together.
  assign do_norm = (min_pm >= HALF);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      norm_pm[i] = nxt_pm[i] - (do_norm ? HALF : '0);
    end
  end

`ifdef ACS_SCHED_BEST_STATE_EN
  logic [1:0]      best_idx;
  logic [PM_W-1:0] best_pm;

  // Strict compare keeps the lowest index on ties; a common offset does not change the argmin.
  always_comb begin
    best_idx = 2'd0;
    best_pm  = nxt_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (nxt_pm[i] < best_pm) begin
        best_pm  = nxt_pm[i];
        best_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_state <= 2'd0;
    end else if (state == COMMIT) begin
      best_state <= best_idx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      sym_q      <= 2'd0;
      surv_q     <= 4'd0;
      surv_bits  <= 4'd0;
      surv_valid <= 1'b0;
      pm[0]      <= '0;
      for (int i = 1; i < 4; i++) pm[i] <= INIT_V;
      for (int i = 0; i < 4; i++) nxt_pm[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            pm[0] <= '0;
            for (int i = 1; i < 4; i++) pm[i] <= INIT_V;
          end
          if (sym_valid) begin
            sym_q <= sym_data;
            idx   <= 2'd0;
            state <= RUN;
          end
        end
        RUN: begin
          nxt_pm[idx] <= acs_pm_out;
          surv_q[idx] <= acs_dec;
          idx         <= idx + 2'd1;
          if (idx == 2'd3) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 4; i++) pm[i] <= norm_pm[i];
          surv_bits  <= surv_q;
          surv_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (surv_ready) begin
            surv_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acs_scheduler.sv
`timescale 1ns/1ps
module tb_acs_scheduler;
  localparam int PM_W    = 7;
  localparam int INIT_PM = 16;
  localparam int HALF    = 64;
  localparam int MODV    = 128;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_start = 1'b0;
  logic            sym_valid = 1'b0;
  logic [1:0]      sym_data = 2'd0;
  logic            sym_ready;
  logic            acs_en;
  logic [1:0]      acs_state;
  logic [1:0]      acs_data;
  logic [PM_W-1:0] acs_pm1;
  logic [PM_W-1:0] acs_pm2;
  logic [PM_W-1:0] acs_pm_out;
  logic            acs_dec;
  logic            surv_valid;
  logic [3:0]      surv_bits;
  logic            surv_ready = 1'b1;
  logic [PM_W-1:0] k_val = '0;
`ifdef ACS_SCHED_BEST_STATE_EN
  logic [1:0]      best_state;
`endif

  acs_scheduler #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .acs_en(acs_en), .acs_state(acs_state), .acs_data(acs_data),
    .acs_pm1(acs_pm1), .acs_pm2(acs_pm2),
    .acs_pm_out(acs_pm_out), .acs_dec(acs_dec),
    .surv_valid(surv_valid), .surv_bits(surv_bits), .surv_ready(surv_ready)
`ifdef ACS_SCHED_BEST_STATE_EN
    , .best_state(best_state)
`endif
  );

  // ACS stub: add-compare-select with a constant branch metric K.
  assign acs_pm_out = ((acs_pm1 < acs_pm2) ? acs_pm1 : acs_pm2) + k_val;
  assign acs_dec    = (acs_pm2 < acs_pm1);

  always #5 clk = ~clk;

  typedef struct { int st; int dat; int p1; int p2; } op_t;
  typedef struct { int bits; int best; } sv_t;

  op_t exp_ops[$];
  sv_t exp_surv[$];
  int  exp_lat[$];
  int  mpm[4];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  rand_rdy_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy_en) begin
      #1 surv_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpm[0] = 0;
    for (int s = 1; s < 4; s++) mpm[s] = INIT_PM;
  endtask

  // Trellis step: state s has predecessors 2*(s%2) and 2*(s%2)+1.
  task automatic model_issue(input int d, input int k, input bit fs);
    int  nv[4];
    int  bits;
    int  mn;
    int  best;
    int  p0;
    op_t op;
    sv_t sv;
    bits = 0;
    best = 0;
    if (fs) model_reset();
    for (int s = 0; s < 4; s++) begin
      p0 = 2 * (s % 2);
      op.st = s; op.dat = d; op.p1 = mpm[p0]; op.p2 = mpm[p0 + 1];
      exp_ops.push_back(op);
      nv[s] = (((mpm[p0] < mpm[p0 + 1]) ? mpm[p0] : mpm[p0 + 1]) + k) % MODV;
      if (mpm[p0 + 1] < mpm[p0]) bits = bits | (1 << s);
    end
    mn = nv[0];
    for (int s = 1; s < 4; s++) begin
      if (nv[s] < mn) begin
        mn = nv[s];
        best = s;
      end
    end
    for (int s = 0; s < 4; s++) mpm[s] = (mn >= HALF) ? nv[s] - HALF : nv[s];
    sv.bits = bits;
    sv.best = best;
    exp_surv.push_back(sv);
    exp_lat.push_back(cyc + 6);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (sym_ready) ok = 1'b1;
    end
    if (!ok) chk(name, 0, 1);
  endtask

  task automatic send_sym(input logic [1:0] d, input int k, input bit fs);
    wait_idle("sym_ready_timeout");
    k_val       = PM_W'(k);
    model_issue(int'(d), k, fs);
    sym_valid   = 1'b1;
    sym_data    = d;
    frame_start = fs;
    @(posedge clk);
    #1;
    sym_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Monitor: compares ACS operands, survivor vectors and latency against the queues.
  always @(negedge clk) begin : monitor
    op_t op;
    sv_t sv;
    int  lat;
    bit  prev_sv;
    if (rst_n) begin
      if (acs_en) begin
        if (exp_ops.size() == 0) chk("unexpected_acs_en", 1, 0);
        else begin
          op = exp_ops.pop_front();
          chk("acs_state", int'(acs_state), op.st);
          chk("acs_data", int'(acs_data), op.dat);
          chk("acs_pm1", int'(acs_pm1), op.p1);
          chk("acs_pm2", int'(acs_pm2), op.p2);
        end
      end
      if (surv_valid && !prev_sv) begin
        if (exp_lat.size() == 0) chk("unexpected_surv_valid", 1, 0);
        else begin
          lat = exp_lat.pop_front();
          chk("surv_latency_cycle", cyc, lat);
        end
      end
      if (surv_valid && surv_ready) begin
        if (exp_surv.size() == 0) chk("unexpected_surv_handshake", 1, 0);
        else begin
          sv = exp_surv.pop_front();
          chk("surv_bits", int'(surv_bits), sv.bits);
`ifdef ACS_SCHED_BEST_STATE_EN
          chk("best_state", int'(best_state), sv.best);
`endif
        end
      end
      prev_sv = surv_valid;
    end else begin
      prev_sv = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sym_ready"}, int'(sym_ready), 1);
    chk({tag, "_acs_en"}, int'(acs_en), 0);
    chk({tag, "_acs_state"}, int'(acs_state), 0);
    chk({tag, "_acs_data"}, int'(acs_data), 0);
    chk({tag, "_acs_pm1"}, int'(acs_pm1), 0);
    chk({tag, "_acs_pm2"}, int'(acs_pm2), 0);
    chk({tag, "_surv_valid"}, int'(surv_valid), 0);
    chk({tag, "_surv_bits"}, int'(surv_bits), 0);
  endtask

  initial begin
    bit ok;
    int exp_bits;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
`ifdef ACS_SCHED_BEST_STATE_EN
    chk("reset_best_state", int'(best_state), 0);
`endif
    #2 rst_n = 1'b1;

    // Single symbol with K=1 from reset.
    send_sym(2'b01, 1, 1'b0);

    // K=40: two symbols from a fresh bank, the second triggers normalization.
    send_sym(2'b11, 40, 1'b1);
    send_sym(2'b00, 40, 1'b0);
    send_sym(2'b10, 5, 1'b0);

    // Stall in OUT for 10 cycles with a stray sym_valid pulse.
    wait_idle("idle_before_stall");
    @(posedge clk);
    #1 surv_ready = 1'b0;
    send_sym(2'b10, 9, 1'b0);
    exp_bits = exp_surv[0].bits;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (surv_valid) ok = 1'b1;
    end
    if (!ok) chk("stall_surv_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_surv_valid", int'(surv_valid), 1);
      chk("stall_surv_bits", int'(surv_bits), exp_bits);
      chk("stall_sym_ready", int'(sym_ready), 0);
      if (i == 3) begin
        sym_valid = 1'b1;
        sym_data  = 2'b11;
      end else begin
        sym_valid = 1'b0;
      end
    end
    sym_valid = 1'b0;
    @(posedge clk);
    #1 surv_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_surv_valid", int'(surv_valid), 0);
    chk("release_sym_ready", int'(sym_ready), 1);

    // Frame restart after several symbols.
    send_sym(2'b01, 3, 1'b0);
    send_sym(2'b10, 11, 1'b0);
    send_sym(2'b11, 7, 1'b0);
    send_sym(2'b00, 2, 1'b1);

    // Asynchronous reset in the middle of RUN at idx=2.
    send_sym(2'b11, 6, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (acs_en && acs_state == 2'd2) ok = 1'b1;
    end
    if (!ok) chk("run_idx2_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    exp_ops.delete();
    exp_surv.delete();
    exp_lat.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_surv_after_reset", int'(surv_valid), 0);
    end
    send_sym(2'b01, 1, 1'b0);

    // Randomized traffic with backpressure and occasional frame restarts.
    rand_rdy_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send_sym(2'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
               ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    rand_rdy_en = 1'b0;
    @(posedge clk);
    #1 surv_ready = 1'b1;
    for (int i = 0; i < 60 && (exp_surv.size() != 0 || exp_ops.size() != 0); i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_pending", exp_surv.size() + exp_ops.size() + exp_lat.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acs_scheduler.md
Name: acs_scheduler

Overview:
Time-multiplexes one combinational ACS unit across the 4 trellis states of the K=3, rate-1/2 Viterbi decoder. Accepts one received symbol pair per handshake and walks states 0..3, feeding predecessor path metrics to the ACS. Collects the updated metrics and survivor bits, then normalizes the path-metric bank. Sits between the symbol input stage and the traceback/survivor memory.

Parameters:
PM_W, 7, path-metric width in bits (shared with the ACS unit)
INIT_PM, 16, reset/frame-start metric for states 1..3 (state 0 starts at 0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  re-initialise PM bank; sampled only in IDLE
sym_valid  in  1  received symbol valid
sym_data  in  2  received code bits
sym_ready  out  1  scheduler can accept a symbol
acs_en  out  1  ACS operands valid this cycle
acs_state  out  2  state index under evaluation
acs_data  out  2  latched symbol to ACS
acs_pm1  out  PM_W  metric of predecessor {s[0],0}
acs_pm2  out  PM_W  metric of predecessor {s[0],1}
acs_pm_out  in  PM_W  ACS selected metric
acs_dec  in  1  ACS decision bit (1 = pm2 path chosen)
surv_valid  out  1  survivor vector valid
surv_bits  out  4  decision bits, bit s = state s
surv_ready  in  1  traceback accepts survivor vector

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; sym_ready = 1; acs_en = 0; acs_state/acs_data/acs_pm1/acs_pm2 = 0; surv_valid = 0; surv_bits = 0.
  - PM[0] = 0; PM[1..3] = INIT_PM.
- FSM states: IDLE, RUN, COMMIT, OUT.
- IDLE:
  - sym_ready = 1.
  - If frame_start = 1, the PM bank is reloaded with its reset values on that edge.
  - If sym_valid = 1 in the same cycle, the symbol is accepted, and the fresh metrics are used for it.
  - On sym_valid & sym_ready: latch sym_data, clear idx, go to RUN.
- RUN (4 cycles, idx = 0..3):
  - acs_en = 1; acs_state = idx; acs_data = latched symbol.
  - acs_pm1 = PM[{idx[0],0}]; acs_pm2 = PM[{idx[0],1}], both read from the old bank.
  - Each edge captures new[idx] = acs_pm_out and surv[idx] = acs_dec.
  - The old bank is not modified during RUN. After idx = 3, go to COMMIT.
- COMMIT (1 cycle):
  - m = min(new[0..3]).
  - If m >= 2^(PM_W-1), PM[i] = new[i] - 2^(PM_W-1); otherwise PM[i] = new[i].
  - Load surv_bits; go to OUT.
- OUT:
  - surv_valid = 1; surv_bits is held stable until surv_ready = 1.
  - On handshake: surv_valid goes to 0 next cycle; go to IDLE.
- Timing:
  - Symbol accepted at edge T0; acs_en is high T0+1..T0+4; COMMIT at T0+5.
  - surv_valid is asserted after the T0+5 edge.
  - Minimum period is 7 cycles per symbol.
- sym_ready = 0 outside IDLE. sym_valid and frame_start are ignored outside IDLE.
- No metric overflow handling beyond normalization. Correct operation requires max branch growth per step < 2^(PM_W-1).
- Reset mid-operation aborts immediately to reset values. The partial survivor vector is discarded.

Optional Feature:
- Macro: ACS_SCHED_BEST_STATE_EN.
- When defined:
  - Adds output best_state[1:0], the index of the minimum normalized metric, computed in COMMIT.
  - Lowest index wins on ties.
  - Valid and stable alongside surv_valid; reset value 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Bench ACS stub: pm_out = min(pm1,pm2) + K, dec = (pm2 < pm1).
2. Reset, stub K=1, symbol 2'b01 -> acs_state 0,1,2,3 on consecutive cycles.
   - acs_pm1/acs_pm2 = 0/16, 16/16, 0/16, 16/16.
   - surv_bits = 4'b0000; new PM = 1,17,1,17; surv_valid 6 cycles after accept.
3. Stub K=40, two symbols from reset.
   - After symbol 1: PM = 40,56,40,56.
   - After symbol 2: all 80, normalized to 16,16,16,16.
4. Hold surv_ready = 0 for 10 cycles in OUT.
   - surv_valid and surv_bits stay stable; sym_ready = 0; a sym_valid pulse is ignored.
   - Release: surv_valid = 0 next cycle, sym_ready = 1.
5. After several symbols, frame_start & sym_valid in the same IDLE cycle.
   - First RUN cycle shows acs_pm1/acs_pm2 = 0/16 (metrics re-initialised).
6. Assert rst_n low during RUN idx=2 -> all outputs go to reset values asynchronously; PM bank = 0,16,16,16; no surv_valid afterwards.
   - With ACS_SCHED_BEST_STATE_EN, scenario 2 gives best_state = 0.
